// File: rtl/u_rca_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// u_rca_seq_pkg
// Shared definitions for the multi-cycle ripple-carry adder controller:
//   - state_t   : controller FSM states
//   - idx_width : width of the slice index counter for a given slice count
// -----------------------------------------------------------------------------
package u_rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // A single-slice configuration still needs a 1-bit index so the counter
    // never collapses to a zero-width vector.
    function automatic int idx_width(input int nslice);
        if (nslice > 1) begin
            return $clog2(nslice);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/u_rca_seq_ctrl_slice.sv
// -----------------------------------------------------------------------------
// u_rca_fa / u_rca_slice
// Purely combinational W-bit ripple-carry slice built from a chain of full
// adder cells. Bit 0 is a full adder as well because the slice carry-in is
// fed from the controller's carry register.
// Ports (u_rca_slice):
//   a, b  [W-1:0]  slice operands
//   cin            carry in
//   sum   [W-1:0]  slice sum
//   cout           carry out of the most significant bit
// -----------------------------------------------------------------------------
module u_rca_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module u_rca_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] chain_s;

    assign chain_s[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        u_rca_fa u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (chain_s[i]),
            .sum  (sum[i]),
            .cout (chain_s[i+1])
        );
    end

    assign cout = chain_s[W];

endmodule

// File: rtl/u_rca_seq_ctrl.sv
// -----------------------------------------------------------------------------
// u_rca_seq_ctrl
// Multi-cycle unsigned adder: adds two OPW-bit operands by passing them
// through one shared SLICEW-bit ripple-carry slice, least-significant slice
// first, one slice per clock. The inter-slice carry lives in a register.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operands a/b valid
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       [OPW-1:0] unsigned operands, sampled only on acceptance
//   out_valid  out_sum holds a completed result
//   out_ready  consumer accepts result
//   out_sum    [OPW:0] a+b, bit OPW is the final carry-out
//   busy       high while an operation is in RUN or DONE
// -----------------------------------------------------------------------------
module u_rca_seq_ctrl #(
    parameter int OPW    = 16,
    parameter int SLICEW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW:0]   out_sum,
    output logic           busy
);

    import u_rca_seq_pkg::*;

    localparam int NSLICE = (SLICEW >= 1) ? (OPW / SLICEW) : 1;
    localparam int IDXW   = idx_width(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    // Reject configurations the slice schedule cannot cover exactly.
    if ((SLICEW < 1) ? 1'b1 : ((OPW % SLICEW) != 0)) begin : g_cfg_err
        $error("u_rca_seq_ctrl: OPW must be a positive multiple of SLICEW");
    end

    state_t          state_r, state_nxt_s;
    logic [IDXW-1:0] idx_r, idx_nxt_s;
    logic            carry_r, carry_nxt_s;
    logic [OPW-1:0]  a_r, a_nxt_s;
    logic [OPW-1:0]  b_r, b_nxt_s;
    logic [OPW:0]    out_sum_r, sum_nxt_s;
    logic            out_valid_r, out_valid_nxt_s;
    logic            in_ready_r, in_ready_nxt_s;
    logic            busy_r, busy_nxt_s;

    logic [SLICEW-1:0] a_slc_s [NSLICE];
    logic [SLICEW-1:0] b_slc_s [NSLICE];
    logic [SLICEW-1:0] slc_a_s, slc_b_s, slc_sum_s;
    logic              slc_cout_s;

    // Split the latched operands into per-pass slices so the active one can be
    // picked by index without a variable part-select.
    for (genvar g = 0; g < NSLICE; g++) begin : g_slc
        assign a_slc_s[g] = a_r[g*SLICEW +: SLICEW];
        assign b_slc_s[g] = b_r[g*SLICEW +: SLICEW];
    end

    assign slc_a_s = a_slc_s[idx_r];
    assign slc_b_s = b_slc_s[idx_r];

    u_rca_slice #(
        .W (SLICEW)
    ) u_slice (
        .a    (slc_a_s),
        .b    (slc_b_s),
        .cin  (carry_r),
        .sum  (slc_sum_s),
        .cout (slc_cout_s)
    );

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        carry_nxt_s = carry_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        sum_nxt_s   = out_sum_r;

        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    a_nxt_s     = a;
                    b_nxt_s     = b;
                    carry_nxt_s = 1'b0;
                    idx_nxt_s   = '0;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (idx_r == IDXW'(i)) begin
                        sum_nxt_s[i*SLICEW +: SLICEW] = slc_sum_s;
                    end else begin
                        sum_nxt_s[i*SLICEW +: SLICEW] = out_sum_r[i*SLICEW +: SLICEW];
                    end
                end
                carry_nxt_s = slc_cout_s;
                // The last pass parks the index instead of wrapping it.
                if (idx_r == LAST_IDX) begin
                    sum_nxt_s[OPW] = slc_cout_s;
                    state_nxt_s    = DONE;
                end else begin
                    idx_nxt_s   = idx_r + 1'b1;
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // Handshake outputs are registered, so derive them from the next state.
        in_ready_nxt_s  = (state_nxt_s == IDLE);
        busy_nxt_s      = (state_nxt_s != IDLE);
        out_valid_nxt_s = (state_nxt_s == DONE);
    end

    // State, datapath and output registers; reset leaves the block idle and ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            carry_r     <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            out_sum_r   <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            carry_r     <= carry_nxt_s;
            a_r         <= a_nxt_s;
            b_r         <= b_nxt_s;
            out_sum_r   <= sum_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign busy      = busy_r;

endmodule
